// File: rtl/oe_noc_pkg.sv
// oe_noc_pkg: port count, direction indices and flit encoding shared by routing and allocation
package oe_noc_pkg;
   localparam int NP = 5;
   localparam int PTR_W = 3;
   localparam int DIR_RIGHT = 0;
   localparam int DIR_LEFT = 1;
   localparam int DIR_UP = 2;
   localparam int DIR_DOWN = 3;
   localparam int DIR_EJECT = 4;
   typedef enum logic [1:0] {
      FLIT_HEAD = 2'd0,
      FLIT_BODY = 2'd1,
      FLIT_TAIL = 2'd2,
      FLIT_SINGLE = 2'd3
   } flit_type_t;
endpackage

// File: rtl/oe_switch_alloc_rr_arbiter.sv
// rr_arbiter: N-way round-robin pick of the first candidate at or after a priority pointer
module rr_arbiter
   import oe_noc_pkg::*;
#(
   parameter int N = NP
) (
   input  logic [N-1:0]     cand,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] idx
);
   int j;
   // scan from the farthest slot back toward ptr so the nearest candidate writes last
   always_comb begin
      gnt = '0;
      idx = '0;
      j = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (cand[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = PTR_W'(j);
         end
      end
   end
endmodule

// File: rtl/oe_switch_alloc.sv
// oe_switch_alloc: round-robin, wormhole-locked, credit-gated switch allocator driving the crossbar
module oe_switch_alloc #(
   parameter int NP = oe_noc_pkg::NP,
   parameter int BUF_DEPTH = 4,
   parameter int CW = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NP*NP-1:0] req,
   input  logic [NP-1:0]    head_valid,
   input  logic [NP-1:0]    tail,
   input  logic [NP-1:0]    credit_in,
   output logic [NP*NP-1:0] grant,
   output logic [NP-1:0]    out_valid,
   output logic [3*NP-1:0]  out_sel,
   output logic             credit_err
);
   localparam int PW = oe_noc_pkg::PTR_W;
   logic [NP-1:0] lock, busy, ogrant, slice;
   logic [PW-1:0] owner [NP];
   logic [PW-1:0] rr [NP];
   logic [PW-1:0] aidx [NP];
   logic [PW-1:0] oidx [NP];
   logic [CW-1:0] credit [NP];
   logic [NP-1:0] sreq [NP];
   logic [NP-1:0] cand [NP];
   logic [NP-1:0] agnt [NP];
   // keep only the lowest request bit per input, drop inputs already holding a lock, transpose per output
   always_comb begin
      busy = '0;
      slice = '0;
      for (int o = 0; o < NP; o++) begin
         cand[o] = '0;
         if (lock[o]) busy[owner[o]] = 1'b1;
      end
      for (int i = 0; i < NP; i++) begin
         slice = req[i*NP +: NP];
         sreq[i] = slice & (~slice + NP'(1)) & {NP{head_valid[i] & ~busy[i]}};
      end
      for (int o = 0; o < NP; o++)
         for (int i = 0; i < NP; i++)
            cand[o][i] = sreq[i][o];
   end
   for (genvar o = 0; o < NP; o++) begin : g_arb
      rr_arbiter #(.N(NP)) u_arb (
         .cand(cand[o]),
         .ptr (rr[o]),
         .gnt (agnt[o]),
         .idx (aidx[o])
      );
   end
   // a locked output serves only its owner, a free one the arbiter winner; both need a credit
   always_comb begin
      ogrant = '0;
      for (int o = 0; o < NP; o++) begin
         oidx[o] = lock[o] ? owner[o] : aidx[o];
         ogrant[o] = (credit[o] != '0) && (lock[o] ? head_valid[owner[o]] : |agnt[o]);
      end
   end
   // crossbar controls, silenced while reset is held low
   always_comb begin
      grant = '0;
      out_valid = '0;
      out_sel = '0;
      for (int o = 0; o < NP; o++)
         if (reset && ogrant[o]) begin
            grant[int'(oidx[o])*NP + o] = 1'b1;
            out_valid[o] = 1'b1;
            out_sel[3*o +: 3] = oidx[o];
         end
   end
   // wormhole lock, round-robin pointer and credit bookkeeping per output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock <= '0;
         credit_err <= 1'b0;
         for (int o = 0; o < NP; o++) begin
            owner[o] <= '0;
            rr[o] <= '0;
            credit[o] <= CW'(BUF_DEPTH);
         end
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (ogrant[o] && !lock[o]) begin
               rr[o] <= (oidx[o] == PW'(NP - 1)) ? '0 : oidx[o] + PW'(1);
               if (!tail[oidx[o]]) begin
                  lock[o] <= 1'b1;
                  owner[o] <= oidx[o];
               end
            end else if (ogrant[o] && tail[oidx[o]]) begin
               lock[o] <= 1'b0;
            end
            if (ogrant[o] && !credit_in[o]) begin
               credit[o] <= credit[o] - CW'(1);
            end else if (!ogrant[o] && credit_in[o]) begin
               if (credit[o] == CW'(BUF_DEPTH)) credit_err <= 1'b1;
               else credit[o] <= credit[o] + CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_oe_switch_alloc.sv
// tb_oe_switch_alloc: directed checks of oe_switch_alloc against a per-cycle reference model
module tb_oe_switch_alloc;
   localparam int NP = 5;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [24:0] req = '0;
   logic [4:0] head_valid = '0, tail = '0, credit_in = '0;
   logic [24:0] grant;
   logic [4:0] out_valid;
   logic [14:0] out_sel;
   logic credit_err;
   int passed = 0, total = 0;
   int m_credit [NP];
   int m_rr [NP];
   int m_owner [NP];
   bit m_lock [NP];
   bit m_err;
   logic [24:0] mg, eg;
   logic [4:0] ev;
   logic [14:0] es;
   int hit;

   oe_switch_alloc #(.NP(5), .BUF_DEPTH(4), .CW(3)) dut (
      .clk(clk), .reset(reset), .req(req), .head_valid(head_valid), .tail(tail),
      .credit_in(credit_in), .grant(grant), .out_valid(out_valid), .out_sel(out_sel),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   // expected grant matrix from the allocation rules and the model's current state
   function automatic logic [24:0] model_grant();
      logic [24:0] g;
      int want [NP];
      int c;
      bit done;
      g = '0;
      for (int i = 0; i < NP; i++) begin
         want[i] = -1;
         if (head_valid[i])
            for (int d = NP - 1; d >= 0; d--)
               if (req[i*NP + d]) want[i] = d;
      end
      for (int o = 0; o < NP; o++) begin
         if (m_credit[o] > 0) begin
            if (m_lock[o]) begin
               if (head_valid[m_owner[o]]) g[m_owner[o]*NP + o] = 1'b1;
            end else begin
               done = 0;
               for (int k = 0; k < NP; k++) begin
                  c = (m_rr[o] + k) % NP;
                  if (!done && want[c] == o) begin
                     g[c*NP + o] = 1'b1;
                     done = 1;
                  end
               end
            end
         end
      end
      return g;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      req = '0;
      head_valid = '0;
      tail = '0;
      credit_in = '0;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int o = 0; o < NP; o++) begin
            m_credit[o] = DEPTH;
            m_rr[o] = 0;
            m_owner[o] = 0;
            m_lock[o] = 0;
         end
         m_err = 0;
      end else begin
         mg = model_grant();
         for (int o = 0; o < NP; o++) begin
            hit = -1;
            for (int i = 0; i < NP; i++)
               if (mg[i*NP + o]) hit = i;
            if (hit >= 0) begin
               if (!m_lock[o]) begin
                  m_rr[o] = (hit + 1) % NP;
                  if (!tail[hit]) begin
                     m_lock[o] = 1;
                     m_owner[o] = hit;
                  end
               end else if (tail[hit]) begin
                  m_lock[o] = 0;
               end
            end
            if (credit_in[o] && hit < 0 && m_credit[o] == DEPTH) m_err = 1;
            else m_credit[o] = m_credit[o] + (credit_in[o] ? 1 : 0) - (hit >= 0 ? 1 : 0);
         end
      end
   end

   always @(negedge clk) begin
      eg = reset ? model_grant() : '0;
      ev = '0;
      es = '0;
      for (int o = 0; o < NP; o++)
         for (int i = 0; i < NP; i++)
            if (eg[i*NP + o]) begin
               ev[o] = 1'b1;
               es[3*o +: 3] = 3'(i);
            end
      chk("cyc_grant", grant, eg);
      chk("cyc_out_valid", out_valid, ev);
      chk("cyc_out_sel", out_sel, es);
      chk("cyc_credit_err", credit_err, m_err);
   end

   initial begin
      clr();
      tick();
      tick();
      req[4] = 1'b1;
      head_valid[0] = 1'b1;
      tail[0] = 1'b1;
      #2 chk("reset_gates_grant", grant, 0);
      #1 reset = 1'b1;
      #2 chk("t1_grant_eject", grant, 32'h10);
      chk("t1_out_valid", out_valid, 5'b10000);
      chk("t1_out_sel", out_sel[14:12], 0);
      tick();
      clr();
      #2 chk("t1_credit", m_credit[4], 3);
      chk("t1_no_lock", m_lock[4], 0);
      tick();
      req[5] = 1'b1;
      req[10] = 1'b1;
      req[15] = 1'b1;
      head_valid[3:1] = 3'b111;
      tail[3:1] = 3'b111;
      #2 chk("t2_win1", out_sel[2:0], 1);
      chk("t2_grant1", grant, 32'h20);
      tick();
      #2 chk("t2_win2", out_sel[2:0], 2);
      chk("t2_grant2", grant, 1 << 10);
      tick();
      #2 chk("t2_win3", out_sel[2:0], 3);
      tick();
      clr();
      #2 chk("t2_rr", m_rr[0], 4);
      chk("t2_credit", m_credit[0], 1);
      tick();
      req[12] = 1'b1;
      head_valid[2] = 1'b1;
      #2 chk("t3_head", grant, 1 << 12);
      tick();
      req[22] = 1'b1;
      head_valid[4] = 1'b1;
      tail[4] = 1'b1;
      #2 chk("t3_body_locked", grant, 1 << 12);
      tick();
      tail[2] = 1'b1;
      #2 chk("t3_tail", grant, 1 << 12);
      tick();
      req[12] = 1'b0;
      head_valid[2] = 1'b0;
      tail[2] = 1'b0;
      #2 chk("t3_after_tail", grant, 1 << 22);
      chk("t3_sel", out_sel[8:6], 4);
      tick();
      clr();
      tick();
      req[18] = 1'b1;
      head_valid[3] = 1'b1;
      tail[3] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #2 chk("t4_grant", grant, 1 << 18);
         tick();
      end
      #2 chk("t4_stall", grant, 0);
      chk("t4_stall_valid", out_valid, 0);
      tick();
      credit_in[3] = 1'b1;
      #2 chk("t4_credit_cycle", grant, 0);
      tick();
      credit_in[3] = 1'b0;
      #2 chk("t4_after_credit", grant, 1 << 18);
      tick();
      clr();
      tick();
      req[1] = 1'b1;
      head_valid[0] = 1'b1;
      tail[0] = 1'b1;
      #2 chk("t5_grant", grant, 2);
      tick();
      tick();
      credit_in[1] = 1'b1;
      #2 chk("t5_grant_with_credit", grant, 2);
      tick();
      clr();
      #2 chk("t5_credit_held", m_credit[1], 2);
      credit_in[1] = 1'b1;
      tick();
      tick();
      #2 chk("t5_credit_full", m_credit[1], 4);
      chk("t5_no_err", credit_err, 0);
      tick();
      credit_in[1] = 1'b0;
      #2 chk("t5_err_set", credit_err, 1);
      tick();
      #2 chk("t5_err_sticky", credit_err, 1);
      tick();
      credit_in[0] = 1'b1;
      tick();
      tick();
      tick();
      credit_in[0] = 1'b0;
      req[5] = 1'b1;
      head_valid[1] = 1'b1;
      #2 chk("t6_head", grant, 1 << 5);
      tick();
      #1 reset = 1'b0;
      #1 chk("t6_reset_grant", grant, 0);
      chk("t6_reset_valid", out_valid, 0);
      chk("t6_reset_sel", out_sel, 0);
      tick();
      clr();
      #1 reset = 1'b1;
      #1;
      for (int o = 0; o < NP; o++) chk("t6_credit", m_credit[o], 4);
      chk("t6_err_cleared", credit_err, 0);
      req[15] = 1'b1;
      head_valid[3] = 1'b1;
      tail[3] = 1'b1;
      #1 chk("t6_lock_dropped", grant, 1 << 15);
      tick();
      clr();
      tick();
      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
